// File: rtl/pnr_pulse_classifier_if.sv
// Signal bundle between the PNR top level and the pulse classifier:
// sample/threshold inputs toward the classifier, classification results back.
interface pnr_pulse_classifier_if #(
  parameter int DW   = 14,
  parameter int NLEV = 7,
  parameter int NW   = 3
);
  logic                  EN;
  logic signed [DW-1:0]  ADC_A;
  logic signed [DW-1:0]  TRIG_HI;
  logic signed [DW-1:0]  TRIG_LO;
  logic [NLEV*DW-1:0]    LEVELS;
  logic [NW-1:0]         PHOTON_NUM;
  logic                  PHOTON_VALID;
  logic signed [DW-1:0]  PEAK;
  logic                  TIMEOUT;
  logic [7:0]            GPIO_WORD;
  logic [31:0]           EVENT_COUNT;

  modport master (
    output EN, ADC_A, TRIG_HI, TRIG_LO, LEVELS,
    input  PHOTON_NUM, PHOTON_VALID, PEAK, TIMEOUT, GPIO_WORD, EVENT_COUNT
  );

  modport slave (
    input  EN, ADC_A, TRIG_HI, TRIG_LO, LEVELS,
    output PHOTON_NUM, PHOTON_VALID, PEAK, TIMEOUT, GPIO_WORD, EVENT_COUNT
  );
endinterface

// File: rtl/pnr_pulse_classifier.sv
// Detects pulses on one signed ADC channel, tracks each pulse's peak and classifies
// it against a threshold ladder into a photon number with a one-cycle valid strobe.
module pnr_pulse_classifier #(
  parameter int DW       = 14,
  parameter int NLEV     = 7,
  parameter int NW       = 3,
  parameter int MAX_LEN  = 255,
  parameter int HOLD_CYC = 16
) (
  input  logic                  ADC_CLK,
  input  logic                  RST,
  pnr_pulse_classifier_if.slave bus
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PULSE    = 2'd1,
    ST_CLASSIFY = 2'd2,
    ST_REARM    = 2'd3
  } state_e;

  // Count rule: every threshold at or below the peak adds one, whatever the ladder order.
  function automatic logic [NW-1:0] count_levels(input logic signed [DW-1:0] pk,
                                                 input logic [NLEV*DW-1:0]   lv);
    logic [NW-1:0] n;
    n = '0;
    for (int k = 0; k < NLEV; k++) begin
      if (pk >= $signed(lv[k*DW +: DW])) begin
        n = n + NW'(1'b1);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  logic [1:0]           rst_sync_q;
  logic                 rst_int_s;

  state_e               state_q, state_d;
  logic signed [DW-1:0] s_q;
  logic signed [DW-1:0] peak_q, peak_d;
  logic [LW-1:0]        len_q, len_d;
  logic                 to_q, to_d;

  logic                 pend_q, pend_d;
  logic [NW-1:0]        res_n_q, res_n_d;
  logic signed [DW-1:0] res_peak_q, res_peak_d;
  logic                 res_to_q, res_to_d;

  logic [NW-1:0]        num_q, num_d;
  logic                 valid_q, valid_d;
  logic signed [DW-1:0] peak_o_q, peak_o_d;
  logic                 timeout_q, timeout_d;
  logic [31:0]          count_q, count_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [7:0]           gpio_s;

  // Reset asserts at once and releases two clock edges after RST falls.
  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
  end

  assign rst_int_s = rst_sync_q[1];

  // Sample capture, pulse tracking and result staging registers.
  always_ff @(posedge ADC_CLK or posedge rst_int_s) begin
    if (rst_int_s) begin
      s_q        <= '0;
      state_q    <= ST_IDLE;
      peak_q     <= '0;
      len_q      <= '0;
      to_q       <= 1'b0;
      pend_q     <= 1'b0;
      res_n_q    <= '0;
      res_peak_q <= '0;
      res_to_q   <= 1'b0;
    end else begin
      s_q        <= bus.ADC_A;
      state_q    <= state_d;
      peak_q     <= peak_d;
      len_q      <= len_d;
      to_q       <= to_d;
      pend_q     <= pend_d;
      res_n_q    <= res_n_d;
      res_peak_q <= res_peak_d;
      res_to_q   <= res_to_d;
    end
  end

  // Pulse FSM: trigger, peak/length tracking, classification, re-arm on the tail.
  always_comb begin
    state_d    = state_q;
    peak_d     = peak_q;
    len_d      = len_q;
    to_d       = to_q;
    pend_d     = 1'b0;
    res_n_d    = res_n_q;
    res_peak_d = res_peak_q;
    res_to_d   = res_to_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.EN && (s_q > bus.TRIG_HI)) begin
          peak_d  = s_q;
          len_d   = LW'(1'b1);
          to_d    = 1'b0;
          state_d = ST_PULSE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PULSE: begin
        if (!bus.EN) begin
          state_d = ST_IDLE;
        end else if (s_q < bus.TRIG_LO) begin
          // The sample that ends the pulse is deliberately left out of the peak.
          to_d    = 1'b0;
          state_d = ST_CLASSIFY;
        end else begin
          peak_d = (s_q > peak_q) ? s_q : peak_q;
          if (len_q == LW'(MAX_LEN)) begin
            to_d    = 1'b1;
            state_d = ST_CLASSIFY;
          end else begin
            len_d = len_q + LW'(1'b1);
          end
        end
      end
      ST_CLASSIFY: begin
        res_n_d    = count_levels(peak_q, bus.LEVELS);
        res_peak_d = peak_q;
        res_to_d   = to_q;
        pend_d     = 1'b1;
        state_d    = ST_REARM;
      end
      ST_REARM: begin
        if (!bus.EN || (s_q < bus.TRIG_LO)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REARM;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output register update: publish a staged result, run the GPIO stretch counter.
  always_comb begin
    valid_d   = pend_q;
    num_d     = num_q;
    peak_o_d  = peak_o_q;
    timeout_d = timeout_q;
    count_d   = count_q;
    hold_d    = hold_q;
    if (pend_q) begin
      num_d     = res_n_q;
      peak_o_d  = res_peak_q;
      timeout_d = res_to_q;
      count_d   = count_q + 32'd1;
      hold_d    = HW'(HOLD_CYC);
    end else if (hold_q != '0) begin
      hold_d = hold_q - HW'(1'b1);
    end else begin
      hold_d = hold_q;
    end
  end

  // Result outputs and stretch counter.
  always_ff @(posedge ADC_CLK or posedge rst_int_s) begin
    if (rst_int_s) begin
      valid_q   <= 1'b0;
      num_q     <= '0;
      peak_o_q  <= '0;
      timeout_q <= 1'b0;
      count_q   <= '0;
      hold_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      num_q     <= num_d;
      peak_o_q  <= peak_o_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
      hold_q    <= hold_d;
    end
  end

  // GPIO word assembled from registered result fields only.
  always_comb begin
    gpio_s           = 8'h00;
    gpio_s[NW-1:0]   = num_q;
    gpio_s[6]        = timeout_q;
    gpio_s[7]        = (hold_q != '0);
  end

  assign bus.PHOTON_NUM   = num_q;
  assign bus.PHOTON_VALID = valid_q;
  assign bus.PEAK         = peak_o_q;
  assign bus.TIMEOUT      = timeout_q;
  assign bus.GPIO_WORD    = gpio_s;
  assign bus.EVENT_COUNT  = count_q;

endmodule

// File: tb/tb_pnr_pulse_classifier.sv
// Self-checking bench: directed scenarios plus randomized pulse trains checked
// against an index-scanning reference model of the classification rules.
module tb_pnr_pulse_classifier;
  localparam int DW = 14, NLEV = 7, NW = 3, MAXL = 8, HOLD = 16;
  localparam int HI = 1000, LO = 800;

  typedef struct packed {
    logic [31:0]   cyc;
    logic [NW-1:0] n;
    logic          to;
    logic [DW-1:0] peak;
    logic [31:0]   cnt;
    logic [6:0]    g;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   ev_total = 0;
  int   lvl[NLEV];
  int   stim_q[$];
  ev_t  obs_q[$];
  ev_t  exp_q[$];
  bit   g7_q[$];

  pnr_pulse_classifier_if #(.DW(DW), .NLEV(NLEV), .NW(NW)) bus ();

  pnr_pulse_classifier #(.DW(DW), .NLEV(NLEV), .NW(NW), .MAX_LEN(MAXL), .HOLD_CYC(HOLD)) dut (
    .ADC_CLK(clk),
    .RST    (rst),
    .bus    (bus)
  );

  always #4 clk = ~clk;

  task automatic set_levels();
    for (int k = 0; k < NLEV; k++) bus.LEVELS[k*DW +: DW] = DW'(lvl[k]);
  endtask

  task automatic push_n(input int v, input int cnt);
    for (int a = 0; a < cnt; a++) stim_q.push_back(v);
  endtask

  // Drives stim_q one sample per edge; records strobes and the stretched-valid bit.
  task automatic run_seq();
    ev_t e;
    obs_q.delete();
    g7_q.delete();
    for (int c = 0; c < stim_q.size(); c++) begin
      @(negedge clk);
      bus.ADC_A = DW'(stim_q[c]);
      @(posedge clk);
      #1;
      g7_q.push_back(bus.GPIO_WORD[7]);
      if (bus.PHOTON_VALID === 1'b1) begin
        e.cyc = 32'(c); e.n = bus.PHOTON_NUM; e.to = bus.TIMEOUT;
        e.peak = bus.PEAK; e.cnt = bus.EVENT_COUNT; e.g = bus.GPIO_WORD[6:0];
        obs_q.push_back(e);
      end
    end
  endtask

  // Reference: find trigger, scan pulse to its end or length limit, take the max,
  // count ladder hits, then wait for a sub-release sample before looking again.
  function automatic void model();
    int n, i, j, m, pk, nn, r, cnt;
    bit to;
    ev_t e;
    n = stim_q.size(); i = 0; cnt = ev_total;
    exp_q.delete();
    while (i < n) begin
      if (stim_q[i] > HI) begin
        pk = stim_q[i]; m = 1; j = -1; to = 1'b0;
        while (j < 0 && i + m < n) begin
          if (stim_q[i+m] < LO) j = i + m;
          else begin
            if (stim_q[i+m] > pk) pk = stim_q[i+m];
            if (m == MAXL) begin j = i + m; to = 1'b1; end
            else m++;
          end
        end
        if (j < 0) break;
        nn = 0;
        for (int k = 0; k < NLEV; k++) if (pk >= lvl[k]) nn++;
        cnt++;
        e.cyc = 32'(j + 3); e.n = NW'(nn); e.to = to; e.peak = DW'(pk);
        e.cnt = 32'(cnt); e.g = {to, 3'b000, NW'(nn)};
        exp_q.push_back(e);
        r = j + 2;
        while (r < n && stim_q[r] >= LO) r++;
        i = r + 1;
      end else i++;
    end
    ev_total = cnt;
  endfunction

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.PHOTON_NUM, bus.PHOTON_VALID, bus.PEAK, bus.TIMEOUT, bus.GPIO_WORD, bus.EVENT_COUNT} !== '0) begin
      errors++; $display("FAIL reset_outputs got num=%0d v=%b peak=%0d to=%b gpio=%h cnt=%0d exp all 0",
        bus.PHOTON_NUM, bus.PHOTON_VALID, bus.PEAK, bus.TIMEOUT, bus.GPIO_WORD, bus.EVENT_COUNT);
    end
    @(negedge clk) rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    stim_q.delete(); push_n(0, 4);
    stim_q.push_back(900); stim_q.push_back(2000); stim_q.push_back(3100);
    stim_q.push_back(1200); stim_q.push_back(0); push_n(0, 24);
    model(); run_seq();
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_events got %0d exp %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_ev%0d got %p exp %p", i, obs_q[i], exp_q[i]); end end
    checks++;
    if (obs_q.size() != 1 || obs_q[0].n !== 3'd2 || obs_q[0].peak !== DW'(3100) || obs_q[0].cyc !== 32'd11 || obs_q[0].cnt !== 32'd1) begin
      errors++; $display("FAIL basic_plan got %p exp n=2 peak=3100 cyc=11 cnt=1", (obs_q.size() > 0) ? obs_q[0] : '0);
    end
  endtask

  task automatic test_threshold_equality();
    stim_q.delete(); push_n(0, 4); stim_q.push_back(1000); push_n(0, 4);
    stim_q.push_back(1100); stim_q.push_back(1200); stim_q.push_back(800);
    stim_q.push_back(2500); stim_q.push_back(0); push_n(0, 24);
    model(); run_seq();
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL equal_events got %0d exp %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL equal_ev%0d got %p exp %p", i, obs_q[i], exp_q[i]); end end
    checks++;
    if (obs_q.size() != 1 || obs_q[0].n !== 3'd2 || obs_q[0].peak !== DW'(2500)) begin
      errors++; $display("FAIL equal_plan got %0d events exp 1 with n=2 peak=2500", obs_q.size());
    end
  endtask

  task automatic test_timeout();
    stim_q.delete(); push_n(0, 4); push_n(5000, 20); push_n(0, 3);
    stim_q.push_back(3000); stim_q.push_back(0); push_n(0, 24);
    model(); run_seq();
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL timeout_events got %0d exp %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL timeout_ev%0d got %p exp %p", i, obs_q[i], exp_q[i]); end end
    checks++;
    if (obs_q.size() != 2 || obs_q[0].n !== 3'd4 || obs_q[0].to !== 1'b1 || obs_q[1].n !== 3'd2 || obs_q[1].to !== 1'b0) begin
      errors++; $display("FAIL timeout_plan got %0d events exp 2 (n=4 to=1, n=2 to=0)", obs_q.size());
    end
  endtask

  task automatic test_hysteresis();
    stim_q.delete(); push_n(-8192, 5);
    stim_q.push_back(1050); stim_q.push_back(850); stim_q.push_back(1600);
    stim_q.push_back(900); stim_q.push_back(1050); stim_q.push_back(-100);
    push_n(-8192, 24);
    model(); run_seq();
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL hyst_events got %0d exp %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL hyst_ev%0d got %p exp %p", i, obs_q[i], exp_q[i]); end end
    checks++;
    if (obs_q.size() != 1 || obs_q[0].n !== 3'd1 || obs_q[0].peak !== DW'(1600)) begin
      errors++; $display("FAIL hyst_plan got %0d events exp 1 with n=1 peak=1600", obs_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int hi_cnt, first, last;
    stim_q.delete(); push_n(0, 4);
    stim_q.push_back(1600); push_n(0, 3); stim_q.push_back(2600); stim_q.push_back(0);
    push_n(0, 30);
    model(); run_seq();
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_events got %0d exp %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_ev%0d got %p exp %p", i, obs_q[i], exp_q[i]); end end
    checks++;
    if (obs_q.size() != 2 || obs_q[1].cyc - obs_q[0].cyc != 32'd4 || obs_q[0].n !== 3'd1 || obs_q[1].n !== 3'd2) begin
      errors++; $display("FAIL b2b_plan got %0d events exp 2 spaced 4 with n=1,2", obs_q.size());
    end
    hi_cnt = 0; first = -1; last = -1;
    foreach (g7_q[c]) if (g7_q[c]) begin hi_cnt++; if (first < 0) first = c; last = c; end
    checks++;
    if (hi_cnt != 20 || last - first != 19) begin
      errors++; $display("FAIL b2b_stretch got %0d high cycles span %0d exp 20 contiguous", hi_cnt, last - first + 1);
    end
  endtask

  task automatic test_enable();
    int sa[14] = '{0, 3000, 3000, 3000, 3000, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    bit ea[14] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    int sb[10] = '{0, 3000, 0, 0, 0, 0, 0, 0, 0, 0};
    bit eb[10] = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1};
    int nv, vc;
    nv = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk); bus.ADC_A = DW'(sa[c]); bus.EN = ea[c];
      @(posedge clk); #1;
      if (bus.PHOTON_VALID === 1'b1) nv++;
    end
    checks++;
    if (nv != 0 || bus.EVENT_COUNT !== 32'(ev_total)) begin
      errors++; $display("FAIL en_abort got %0d strobes cnt=%0d exp 0 strobes cnt=%0d", nv, bus.EVENT_COUNT, ev_total);
    end
    nv = 0; vc = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); bus.ADC_A = DW'(sb[c]); bus.EN = eb[c];
      @(posedge clk); #1;
      if (bus.PHOTON_VALID === 1'b1) begin nv++; vc = c; end
      if (c == 6) begin
        checks++;
        if (bus.PHOTON_NUM !== 3'd2 || bus.PEAK !== DW'(3000) || bus.PHOTON_VALID !== 1'b0) begin
          errors++; $display("FAIL en_hold got num=%0d peak=%0d v=%b exp 2 3000 0", bus.PHOTON_NUM, bus.PEAK, bus.PHOTON_VALID);
        end
      end
    end
    ev_total++;
    checks++;
    if (nv != 1 || vc != 5 || bus.EVENT_COUNT !== 32'(ev_total)) begin
      errors++; $display("FAIL en_classify got %0d strobes at %0d cnt=%0d exp 1 at 5 cnt=%0d", nv, vc, bus.EVENT_COUNT, ev_total);
    end
    stim_q.delete(); push_n(0, 4); stim_q.push_back(4000); stim_q.push_back(0); push_n(0, 24);
    model(); run_seq();
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL en_next_events got %0d exp %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL en_next_ev%0d got %p exp %p", i, obs_q[i], exp_q[i]); end end
  endtask

  task automatic test_reset_mid_pulse();
    int nv;
    @(negedge clk) bus.ADC_A = DW'(0);
    @(negedge clk) bus.ADC_A = DW'(3000);
    @(negedge clk) bus.ADC_A = DW'(3000);
    @(negedge clk) bus.ADC_A = DW'(3500);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.PHOTON_NUM, bus.PHOTON_VALID, bus.PEAK, bus.TIMEOUT, bus.GPIO_WORD, bus.EVENT_COUNT} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs got num=%0d peak=%0d gpio=%h cnt=%0d exp all 0",
        bus.PHOTON_NUM, bus.PEAK, bus.GPIO_WORD, bus.EVENT_COUNT);
    end
    bus.ADC_A = DW'(0);
    nv = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ev_total = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus.PHOTON_VALID === 1'b1) nv++;
    end
    checks++;
    if (nv != 0) begin errors++; $display("FAIL rst_mid_strobe got %0d strobes exp 0", nv); end
    stim_q.delete(); push_n(0, 4); stim_q.push_back(2000); stim_q.push_back(0); push_n(0, 24);
    model(); run_seq();
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rst_next_events got %0d exp %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_next_ev%0d got %p exp %p", i, obs_q[i], exp_q[i]); end end
    checks++;
    if (obs_q.size() != 1 || obs_q[0].cnt !== 32'd1 || obs_q[0].n !== 3'd1) begin
      errors++; $display("FAIL rst_next_plan got %0d events exp 1 with cnt=1 n=1", obs_q.size());
    end
  endtask

  task automatic test_random();
    int bad, nl, plen;
    bit g;
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < NLEV; k++) lvl[k] = int'($urandom_range(0, 10191)) - 2000;
      set_levels();
      stim_q.delete();
      for (int seg = 0; seg < 8; seg++) begin
        nl = int'($urandom_range(1, 4));
        for (int a = 0; a < nl; a++)
          stim_q.push_back(($urandom_range(0, 3) == 0) ? -8192 : int'($urandom_range(0, 8991)) - 8192);
        plen = int'($urandom_range(1, 11));
        stim_q.push_back(int'($urandom_range(1001, 8191)));
        for (int a = 1; a < plen; a++)
          stim_q.push_back(($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 16383)) - 8192
                                                       : int'($urandom_range(800, 8191)));
      end
      push_n(0, 24);
      model(); run_seq();
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_events got %0d exp %0d", it, obs_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < obs_q.size()) begin checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_ev%0d got %p exp %p", it, i, obs_q[i], exp_q[i]); end end
      bad = 0;
      foreach (g7_q[c]) begin
        g = 1'b0;
        foreach (exp_q[i]) if (c >= int'(exp_q[i].cyc) && c < int'(exp_q[i].cyc) + HOLD) g = 1'b1;
        if (g7_q[c] != g) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rand%0d_stretch got %0d wrong cycles exp 0", it, bad); end
    end
  endtask

  initial begin
    bus.EN      = 1'b1;
    bus.ADC_A   = DW'(0);
    bus.TRIG_HI = DW'(HI);
    bus.TRIG_LO = DW'(LO);
    for (int k = 0; k < NLEV; k++) lvl[k] = 1500 + 1000 * k;
    set_levels();
    test_reset();
    test_basic();
    test_threshold_equality();
    test_timeout();
    test_hysteresis();
    test_back_to_back();
    test_enable();
    test_reset_mid_pulse();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pnr_pulse_classifier.md
Name: pnr_pulse_classifier

Overview:
- Front-end stage feeding the PNR top level.
- Watches one 14-bit signed ADC channel for detector pulses and tracks each pulse's peak.
- On pulse end, classifies the peak against a programmable ascending threshold ladder and emits a photon number with a one-cycle valid strobe.
- The PNR top level drives the extension GPIO from these outputs.

Parameters:
- DW, 14, ADC sample width (two's complement).
- NLEV, 7, number of ladder thresholds; photon number range 0..NLEV.
- NW, 3, photon-number width; must satisfy 2^NW > NLEV.
- MAX_LEN, 255, maximum pulse length in samples before forced end (timeout).
- HOLD_CYC, 16, cycles GPIO_WORD holds a result after a pulse.

Ports:
- ADC_CLK  in  1  sample clock, 125 MHz; all logic on rising edge.
- RST  in  1  asynchronous active-high reset.
- EN  in  1  enable; 0 forces IDLE at next edge and blocks new triggers.
- ADC_A  in  DW  signed sample.
- TRIG_HI  in  DW  signed trigger level; pulse starts when sample > TRIG_HI.
- TRIG_LO  in  DW  signed release level; pulse ends when sample < TRIG_LO. Hysteresis: TRIG_LO <= TRIG_HI.
- LEVELS  in  NLEV*DW  flattened signed thresholds; bits [k*DW +: DW] = LEVEL[k].
- PHOTON_NUM  out  NW  result; valid while PHOTON_VALID = 1, held until next result.
- PHOTON_VALID  out  1  one-cycle strobe per classified pulse.
- PEAK  out  DW  signed peak of the last pulse; updates with PHOTON_VALID.
- TIMEOUT  out  1  sticky per result: the last pulse hit MAX_LEN.
- GPIO_WORD  out  8  [NW-1:0] = PHOTON_NUM, [7] = stretched valid (HOLD_CYC cycles), [6] = TIMEOUT, other bits 0.
- EVENT_COUNT  out  32  number of classified pulses; wraps at 2^32.

Behaviour:
- Reset (async assert, sync deassert internally):
  - All outputs 0.
  - State IDLE.
  - Input register, peak, length and hold counters cleared.
- Input register: ADC_A captured every edge into s. The FSM operates on s only.
- States:
  - IDLE: if EN and s > TRIG_HI (signed): peak <= s, len <= 1, go to PULSE.
  - PULSE:
    - peak <= max(peak, s) (signed); len <= len+1.
    - If s < TRIG_LO: go to CLASSIFY with to_flag = 0. The ending sample is not included in the peak.
    - Else if len == MAX_LEN: go to CLASSIFY with to_flag = 1.
  - CLASSIFY (1 cycle):
    - n = count of k in 0..NLEV-1 with peak >= LEVEL[k] (signed). Count rule, so non-monotonic ladders are still defined.
    - Register PHOTON_NUM = n, PEAK = peak, TIMEOUT = to_flag.
    - Pulse PHOTON_VALID; increment EVENT_COUNT; load hold counter = HOLD_CYC.
    - Go to REARM.
  - REARM: stay until s < TRIG_LO, then go to IDLE. Prevents retrigger on the tail of a timed-out pulse.
- Latency: the ADC_A sample that ends a pulse, presented at edge t, gives PHOTON_VALID high during cycle t+3 → t+4. Minimum event spacing is 4 samples (1-sample pulse).
- GPIO_WORD[7]:
  - High while the hold counter is nonzero; the counter decrements each cycle.
  - A new result reloads the counter, so back-to-back pulses extend the stretch.
- EN:
  - EN = 0 in PULSE aborts to IDLE with no result.
  - EN = 0 in CLASSIFY still completes that result.
  - Outputs hold their values while EN = 0.
- Boundaries:
  - s == TRIG_HI does not trigger; s == TRIG_LO does not end a pulse.
  - Peak equal to a LEVEL counts toward n.
  - All levels above peak gives n = 0.
  - Most-negative sample (-8192) is handled signed, never as a large unsigned value.
- Reset mid-pulse: immediate return to IDLE, no result emitted.

Test Plan:
- TRIG_HI=1000, TRIG_LO=800, LEVELS=1500,2500,...,7500 (step 1000); ADC_A baseline 0, pulse 900,2000,3100,1200,0 → PHOTON_NUM=2, PEAK=3100, PHOTON_VALID one cycle 3 edges after the sample 0, EVENT_COUNT=1.
- Threshold equality: pulse peak exactly 2500 → PHOTON_NUM=2. Sample exactly 1000 at baseline → no trigger, EVENT_COUNT unchanged.
- Timeout, MAX_LEN=8: constant 5000 for 20 samples, then 0 → one result with PHOTON_NUM=4 and TIMEOUT=1. No second event until ADC_A < 800; then a fresh pulse is classified normally.
- Negative/hysteresis: baseline -8192, pulse peak 1600 dithering between 850 and 1050 before falling to -100 → exactly one event, PHOTON_NUM=1.
- Back-to-back 1-sample pulses (1600,0,0,0,2600,0) with HOLD_CYC=16 → two strobes 4 cycles apart, results 1 then 2, GPIO_WORD[7] high continuously for 20 cycles.
- RST asserted mid-pulse, or EN dropped mid-pulse → no PHOTON_VALID, all outputs 0 after RST, next pulse classified correctly.
